// File: rtl/genesis_audio_mix_if.sv
// Signal bundle between the audio sources and genesis_audio_mix.
//
// Ports (grouped signals):
//   fm_l, fm_r, fm_ce   signed FM stereo sample and its capture strobe
//   psg, psg_ce         signed PSG mono sample and its capture strobe
//   fm_vol, psg_vol     4-bit gains in eighths (0 = mute, 8 = unity)
//   clip_clr            clears the sticky clip flag
//   out_l, out_r        signed mixed stereo output
//   out_valid           one-cycle pulse when out_l/out_r update
//   clip                sticky saturation flag
//   fsm_state           debug view of the mixer sequencer state
//
// Handshake: there is no backpressure anywhere. fm_ce/psg_ce act as valid
// strobes with an implicit, always-high ready: a sample is taken in every
// cycle its strobe is 1, back to back if needed. out_valid is a valid-only
// pulse; the consumer must take out_l/out_r in the cycle it is high (the
// values also hold until the next update).
interface genesis_audio_mix_if;
  logic signed [15:0] fm_l;
  logic signed [15:0] fm_r;
  logic               fm_ce;
  logic signed [15:0] psg;
  logic               psg_ce;
  logic [3:0]         fm_vol;
  logic [3:0]         psg_vol;
  logic               clip_clr;
  logic signed [15:0] out_l;
  logic signed [15:0] out_r;
  logic               out_valid;
  logic               clip;
  logic [2:0]         fsm_state;

  // master: the side that supplies samples and consumes the mix.
  modport master (
    output fm_l, fm_r, fm_ce, psg, psg_ce, fm_vol, psg_vol, clip_clr,
    input  out_l, out_r, out_valid, clip, fsm_state
  );

  // slave: the mixer itself.
  modport slave (
    input  fm_l, fm_r, fm_ce, psg, psg_ce, fm_vol, psg_vol, clip_clr,
    output out_l, out_r, out_valid, clip, fsm_state
  );
endinterface

// File: rtl/genesis_audio_mix.sv
// Genesis audio mixer: combines stereo FM and mono PSG into one stereo
// stream at clk/DIV (106528 Hz for a 53.69 MHz clock and DIV = 504).
// Each source is scaled by a 4-bit gain in eighths, the scaled sources are
// summed per channel, and the sum is saturated to 16 bits with a sticky
// clip flag. A single multiplier is shared by a six-state sequencer.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset (release sampled synchronously)
//   bus    genesis_audio_mix_if.slave (samples, strobes, gains, mix out)
//
// Parameter:
//   DIV    clock cycles per output sample, 8..1023
module genesis_audio_mix #(
  parameter int DIV = 504
) (
  input  logic                  clk,
  input  logic                  reset,
  genesis_audio_mix_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FM_L  = 3'd1,
    PSG_L = 3'd2,
    FM_R  = 3'd3,
    PSG_R = 3'd4,
    OUT   = 3'd5
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(DIV - 1);

  state_t state;

  // Sample-rate divider
  logic [9:0] count;
  logic       tick;

  // Hold registers (written by strobes) and working copies (frozen per sample)
  logic signed [15:0] hold_fm_l;
  logic signed [15:0] hold_fm_r;
  logic signed [15:0] hold_psg;
  logic signed [15:0] w_fm_l;
  logic signed [15:0] w_fm_r;
  logic signed [15:0] w_psg;
  logic [3:0]         vol_fm;
  logic [3:0]         vol_psg;

  // Shared multiplier path
  logic signed [15:0] mul_a;
  logic [3:0]         mul_v;
  logic signed [20:0] prod;
  logic signed [18:0] scaled;

  // Accumulators and saturation results ({flag, value})
  logic signed [18:0] acc_l;
  logic signed [18:0] acc_r;
  logic [16:0]        sat_l;
  logic [16:0]        sat_r;

  // Registered outputs
  logic signed [15:0] out_l_q;
  logic signed [15:0] out_r_q;
  logic               out_valid_q;
  logic               clip_q;

  function automatic logic [16:0] saturate(input logic signed [18:0] a);
    // Positive overflow: any of bits 17..15 set. Negative overflow: bits
    // 18..15 not all ones.
    if (!a[18] && (a[17:15] != 3'b000)) begin
      saturate = {1'b1, 16'h7fff};
    end else if (a[18] && (a[17:15] != 3'b111)) begin
      saturate = {1'b1, 16'h8000};
    end else begin
      saturate = {1'b0, a[15:0]};
    end
  endfunction

  // ---------------------------------------------------------------------
  // Divider: tick marks the last cycle of each sample period.
  // ---------------------------------------------------------------------
  assign tick = (count == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 10'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Capture. A strobe in the tick cycle lands here while the snapshot
  // below still reads the previous hold value, so the new sample waits
  // for the next period.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_fm_l <= '0;
      hold_fm_r <= '0;
      hold_psg  <= '0;
    end else begin
      if (bus.fm_ce) begin
        hold_fm_l <= bus.fm_l;
        hold_fm_r <= bus.fm_r;
      end
      if (bus.psg_ce) begin
        hold_psg <= bus.psg;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Multiplier operand select, keyed on the step being executed.
  // ---------------------------------------------------------------------
  always_comb begin
    mul_a = w_fm_l;
    mul_v = vol_fm;
    case (state)
      FM_L: begin
        mul_a = w_fm_l;
        mul_v = vol_fm;
      end
      PSG_L, PSG_R: begin
        mul_a = w_psg;
        mul_v = vol_psg;
      end
      FM_R: begin
        mul_a = w_fm_r;
        mul_v = vol_fm;
      end
      default: begin
        mul_a = w_fm_l;
        mul_v = vol_fm;
      end
    endcase
  end

  // Gain is zero-extended so it is always non-negative; the product is
  // formed at 21 bits, which holds -32768 * 15 exactly.
  assign prod   = $signed({{5{mul_a[15]}}, mul_a}) * $signed({17'd0, mul_v});
  // Arithmetic shift floors toward -inf; the result fits in 18 bits, so
  // narrowing to the 19-bit accumulator width loses nothing.
  assign scaled = 19'(prod >>> 3);

  assign sat_l = saturate(acc_l);
  assign sat_r = saturate(acc_r);

  // ---------------------------------------------------------------------
  // Sequencer: one step per cycle, IDLE -> FM_L -> PSG_L -> FM_R ->
  // PSG_R -> OUT -> IDLE. A sequence lasts 6 cycles, always shorter than
  // a sample period, so a tick only ever arrives in IDLE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      w_fm_l      <= '0;
      w_fm_r      <= '0;
      w_psg       <= '0;
      vol_fm      <= '0;
      vol_psg     <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            w_fm_l  <= hold_fm_l;
            w_fm_r  <= hold_fm_r;
            w_psg   <= hold_psg;
            vol_fm  <= bus.fm_vol;
            vol_psg <= bus.psg_vol;
            state   <= FM_L;
          end
        end
        FM_L: begin
          acc_l <= scaled;
          state <= PSG_L;
        end
        PSG_L: begin
          acc_l <= acc_l + scaled;
          state <= FM_R;
        end
        FM_R: begin
          acc_r <= scaled;
          state <= PSG_R;
        end
        PSG_R: begin
          acc_r <= acc_r + scaled;
          state <= OUT;
        end
        OUT: begin
          out_l_q     <= sat_l[15:0];
          out_r_q     <= sat_r[15:0];
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // A saturation in OUT wins over a simultaneous clear.
      if ((state == OUT) && (sat_l[16] || sat_r[16])) begin
        clip_q <= 1'b1;
      end else if (bus.clip_clr) begin
        clip_q <= 1'b0;
      end
    end
  end

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = out_valid_q;
  assign bus.clip      = clip_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_genesis_audio_mix.sv
module tb_genesis_audio_mix;
  localparam int DIV = 504;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  genesis_audio_mix_if bus();

  genesis_audio_mix #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: mixes from the arithmetic rules (floor(x*v/8), sum,
  // clamp) and schedules each result 6 cycles after its tick cycle.
  // ---------------------------------------------------------------------
  function automatic int fdiv8(input int x);
    if (x >= 0) return x / 8;
    return -((-x + 7) / 8);
  endfunction

  function automatic int clamp16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  int          pcnt   = 0;
  int          mcount = 0;
  int          m_fm_l = 0;
  int          m_fm_r = 0;
  int          m_psg  = 0;
  int          l_sum;
  int          r_sum;
  bit          satf;
  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          sat_q[$];
  logic [15:0] m_out_l = '0;
  logic [15:0] m_out_r = '0;
  logic        m_valid = 1'b0;
  logic        m_clip  = 1'b0;

  always @(posedge clk) begin
    pcnt++;
    if (!reset) begin
      mcount  = 0;
      m_fm_l  = 0;
      m_fm_r  = 0;
      m_psg   = 0;
      exp_q.delete();
      due_q.delete();
      sat_q.delete();
      m_out_l = '0;
      m_out_r = '0;
      m_valid = 1'b0;
      m_clip  = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == pcnt) begin
        {m_out_l, m_out_r} = exp_q.pop_front();
        void'(due_q.pop_front());
        satf    = sat_q.pop_front();
        m_valid = 1'b1;
        if (satf) m_clip = 1'b1;
        else if (bus.clip_clr) m_clip = 1'b0;
      end else if (bus.clip_clr) begin
        m_clip = 1'b0;
      end
      if (mcount == DIV - 1) begin
        l_sum = fdiv8(m_fm_l * int'(bus.fm_vol)) + fdiv8(m_psg * int'(bus.psg_vol));
        r_sum = fdiv8(m_fm_r * int'(bus.fm_vol)) + fdiv8(m_psg * int'(bus.psg_vol));
        exp_q.push_back({16'(clamp16(l_sum)), 16'(clamp16(r_sum))});
        sat_q.push_back((l_sum != clamp16(l_sum)) || (r_sum != clamp16(r_sum)));
        due_q.push_back(pcnt + 5);
        mcount = 0;
      end else begin
        mcount++;
      end
      if (bus.fm_ce) begin
        m_fm_l = int'(bus.fm_l);
        m_fm_r = int'(bus.fm_r);
      end
      if (bus.psg_ce) m_psg = int'(bus.psg);
    end
  end

  // Scoreboard monitor: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("mon_data_rst", {bus.out_l, bus.out_r}, 32'sd0);
      check("mon_flags_rst", {30'd0, bus.out_valid, bus.clip}, 32'sd0);
    end else begin
      check("mon_data", {bus.out_l, bus.out_r}, {m_out_l, m_out_r});
      check("mon_flags", {30'd0, bus.out_valid, bus.clip}, {30'd0, m_valid, m_clip});
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next out_valid; n = cycles advanced.
  task automatic wait_valid(input string name, input int bound, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      n++;
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s: out_valid not seen within %0d cycles, expected one", name, bound);
    end
  endtask

  // Called in cycle 0 after reset release; returns index of the first
  // cycle with out_valid high (-1 if none within bound).
  task automatic first_valid(input int bound, output int cyc);
    cyc = -1;
    for (int k = 0; k < bound; k++) begin
      if (bus.out_valid === 1'b1) begin
        cyc = k;
        break;
      end
      step();
    end
  endtask

  task automatic load(input int fl, input int fr, input int p, input int fv, input int pv);
    bus.fm_l    = 16'(fl);
    bus.fm_r    = 16'(fr);
    bus.psg     = 16'(p);
    bus.fm_vol  = 4'(fv);
    bus.psg_vol = 4'(pv);
    bus.fm_ce   = 1'b1;
    bus.psg_ce  = 1'b1;
    step();
    bus.fm_ce   = 1'b0;
    bus.psg_ce  = 1'b0;
  endtask

  typedef struct {
    int fm_l;
    int fm_r;
    int psg;
    int fv;
    int pv;
    int el;
    int er;
    int ec;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n;
    int cyc;
    int prev_clip;

    tbl[0] = '{1000, -2000, 500, 8, 8, 1500, -1500, 0};
    tbl[1] = '{30000, 0, 0, 15, 0, 32767, 0, 1};
    tbl[2] = '{0, -20000, 0, 15, 0, 0, -32768, 1};
    tbl[3] = '{-1, 1, 0, 1, 0, -1, 0, 0};
    tbl[4] = '{12345, -12345, -7, 0, 1, -1, -1, 0};
    tbl[5] = '{-32768, 32767, -32768, 15, 15, -32768, -2, 1};
    tbl[6] = '{0, 0, 4000, 0, 4, 2000, 2000, 0};
    tbl[7] = '{10000, -10000, 10000, 15, 15, 32767, 0, 1};

    reset        = 1'b0;
    bus.fm_l     = '0;
    bus.fm_r     = '0;
    bus.psg      = '0;
    bus.fm_ce    = 1'b0;
    bus.psg_ce   = 1'b0;
    bus.fm_vol   = 4'd8;
    bus.psg_vol  = 4'd8;
    bus.clip_clr = 1'b0;

    repeat (3) step();
    check("reset_out_l", bus.out_l, 0);
    check("reset_out_r", bus.out_r, 0);
    check("reset_valid", bus.out_valid, 0);
    check("reset_clip", bus.clip, 0);
    check("reset_state_known", {31'd0, ^bus.fsm_state === 1'bx}, 0);

    // Cadence: release at cycle 0, first output at DIV-1+6, then every DIV.
    reset = 1'b1;
    first_valid(2000, cyc);
    check("first_valid_cycle", cyc, DIV - 1 + 6);
    wait_valid("cadence", 1000, n);
    check("cadence_period", n, DIV);

    // Table-driven mixes.
    prev_clip = 0;
    for (int i = 0; i < 8; i++) begin
      check("clip_hold", bus.clip, prev_clip);
      load(tbl[i].fm_l, tbl[i].fm_r, tbl[i].psg, tbl[i].fv, tbl[i].pv);
      bus.clip_clr = 1'b1;
      step();
      bus.clip_clr = 1'b0;
      check("clip_clr", bus.clip, 0);
      wait_valid("tbl_valid", 1000, n);
      check("tbl_out_l", bus.out_l, tbl[i].el);
      check("tbl_out_r", bus.out_r, tbl[i].er);
      check("tbl_clip", bus.clip, tbl[i].ec);
      step();
      check("valid_width", bus.out_valid, 0);
      check("out_hold", bus.out_l, tbl[i].el);
      prev_clip = tbl[i].ec;
    end

    // Capture race: strobe with 777 in the tick cycle, hold holds 111.
    // Now in cycle T+1 where T had out_valid; tick is cycle T+498.
    bus.fm_l    = 16'sd111;
    bus.fm_r    = 16'sd111;
    bus.fm_vol  = 4'd8;
    bus.psg_vol = 4'd0;
    bus.fm_ce   = 1'b1;
    step();
    bus.fm_ce   = 1'b0;
    repeat (496) step();
    bus.fm_l    = 16'sd777;
    bus.fm_r    = 16'sd777;
    bus.fm_ce   = 1'b1;
    step();
    bus.fm_ce   = 1'b0;
    wait_valid("race_valid0", 100, n);
    check("race_old_l", bus.out_l, 111);
    check("race_old_r", bus.out_r, 111);
    wait_valid("race_valid1", 1000, n);
    check("race_new_l", bus.out_l, 777);
    check("race_new_r", bus.out_r, 777);
    check("clip_sticky", bus.clip, 1);

    // Reset during PSG_L: tick at T+498, FM_L T+499, PSG_L T+500.
    repeat (500) step();
    reset = 1'b0;
    #1;
    check("midrst_out_l", bus.out_l, 0);
    check("midrst_out_r", bus.out_r, 0);
    check("midrst_clip", bus.clip, 0);
    check("midrst_valid", bus.out_valid, 0);
    step();
    reset = 1'b1;
    first_valid(1200, cyc);
    check("midrst_first_valid", cyc, DIV - 1 + 6);
    check("midrst_out_after", bus.out_l, 0);

    // Randomized traffic checked by the reference model.
    for (int i = 0; i < 4000; i++) begin
      bus.fm_ce    = ($urandom_range(0, 3) == 0);
      bus.psg_ce   = ($urandom_range(0, 3) == 0);
      bus.fm_l     = 16'($urandom);
      bus.fm_r     = 16'($urandom);
      bus.psg      = 16'($urandom);
      if ($urandom_range(0, 63) == 0) bus.fm_vol  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) bus.psg_vol = 4'($urandom_range(0, 15));
      bus.clip_clr = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.fm_ce    = 1'b0;
    bus.psg_ce   = 1'b0;
    bus.clip_clr = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
